fir_mac_split_acc: RTL and testbench
====================================

Name: fir_mac_split_acc

Overview:
- Parametrised, pipelined signed multiply-accumulate for FIR tap chains.
- Multiplies a signed sample `a` by a signed wide coefficient `b`.
- `b` is split into an unsigned low slice and a signed high slice. The two partial products are accumulated separately and recombined at the output.
- Adds sequence framing (valid/last), automatic accumulator restart, and round/saturate to a narrower output. Sits between the coefficient/sample delay line and the FIR output register.

Parameters:
- AW, 18, signed width of `a`.
- BW, 36, signed width of `b`.
- LW, 18, width of the unsigned low slice `b[LW-1:0]`. High slice HW = BW-LW is signed. Legal: 1 <= LW <= BW-2.
- ACCW, 68, width of the recombined accumulator. Sum wraps modulo 2^ACCW; the integrator sizes ACCW so overflow cannot occur.
- OW, 68, signed output width. Legal: OW <= ACCW.
- SHIFT, 0, right shift applied before saturation, with round-half-up. Legal: 0 <= SHIFT < ACCW.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  `a`/`b` carry a tap this cycle.
- in_last  in  1  final tap of a sequence; qualified by in_valid.
- a  in  AW  signed sample.
- b  in  BW  signed coefficient.
- out_valid  out  1  one-cycle pulse; result of a completed sequence.
- out_data  out  OW  rounded/saturated sum of the sequence.
- out_sat  out  1  out_data was clipped; qualified by out_valid.

Behaviour:
- Reset, synchronous, active-high, on clock:
  - All pipeline registers, valid/last shift bits and accumulators go to 0.
  - `first` flag goes to 1.
  - out_valid=0, out_data=0, out_sat=0.
- Stage 1: register a, b, in_valid, in_last.
- Stage 2:
  - p_lo = a * $signed({1'b0, b[LW-1:0]}), width AW+LW+1.
  - p_hi = a * b[BW-1:LW], signed, width AW+HW.
  - valid/last delayed alongside.
- Stage 3, accumulate when stage-2 valid:
  - If `first`=1: acc_lo <= p_lo and acc_hi <= p_hi (restart, no clear cycle).
  - Else: accumulators add.
  - `first` <= stage-2 last.
  - When stage-2 valid=0: accumulators and `first` hold (bubble).
  - Accumulator widths: acc_lo ACCW, acc_hi ACCW-LW, both sign-extended.
- Stage 4, update only when stage-3 valid & last:
  - sum = (acc_hi <<< LW) + acc_lo, modulo 2^ACCW.
  - If SHIFT>0: r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic, computed one bit wider to avoid carry loss. If SHIFT=0: r = sum.
  - If r > 2^(OW-1)-1: out_data = max, out_sat=1.
  - If r < -2^(OW-1): out_data = min, out_sat=1.
  - Otherwise out_data = r, out_sat=0.
  - out_valid=1 for that cycle; 0 on every other cycle.
  - out_data/out_sat hold between pulses.
- Latency: in_valid&in_last at cycle N gives out_valid at rising edge N+4.
- Throughput: one tap per cycle. Sequences may be back-to-back; the cycle after in_last may start a new sequence.
- Single-tap sequence (in_last on first tap): result = that product alone.
- in_last with in_valid=0 is ignored.
- Bubbles (in_valid=0) mid-sequence: no effect on the result; latency is counted from the last tap.
- Reset mid-sequence: the partial sum is discarded, no out_valid is produced for it, and the next valid tap starts a new sequence.
- No backpressure: the consumer must accept every out_valid pulse.

Decomposition:
- Package fir_mac_pkg:
  - default widths (AW, BW, LW, ACCW, OW);
  - localparam HW = BW-LW;
  - functions returning signed max/min for a given width, and a round-constant function.
- Sub-module fir_mac_round_sat, which holds stage 4:
  - input sum (ACCW) and valid;
  - outputs out_data, out_sat, out_valid;
  - parameters ACCW, OW, SHIFT.
  - It is reused by other FIR output paths.

Test Plan:
- Single tap a=3, b=5, last=1, defaults -> out_valid exactly 4 cycles later, out_data=15, out_sat=0.
- a=-1, b=0x3FFFF (low slice all ones, high slice 0), last=1 -> out_data=-262143. Checks the unsigned low slice.
- 4-tap sequence a={1,2,3,4}, b={-2^35, 1, 2^18, -1}, with a 2-cycle bubble after tap 2 -> single out_valid, out_data = -2^35 + 2 + 3*2^18 - 4 = -34358951938.
- Back-to-back sequences {a=2,b=7,last} then {a=-5,b=3 ; a=1,b=1,last} with no gap -> two pulses on consecutive relevant cycles, out_data=14 then -14. Confirms no carry-over between sequences.
- OW=16, SHIFT=0: a=131071, b=131072 -> out_data=32767, out_sat=1. Then a=-131072, b=131072 -> -32768, out_sat=1.
- SHIFT=4, OW=16:
  - product 24 -> 2;
  - product -24 -> -1;
  - product 8 -> 1.
- Reset mid-sequence: 3 taps of a=1, b=1, reset for 1 cycle, then tap a=1, b=1, last -> out_valid never pulses for the aborted sequence; the next pulse has out_data=1.

Source files
------------

// File: rtl/fir_mac_pkg.sv
// Shared widths and constant helpers for the FIR multiply-accumulate output paths.
//   Default widths: AW_DEF (sample), BW_DEF (coefficient), LW_DEF (unsigned low slice),
//   HW_DEF (signed high slice), ACCW_DEF (accumulator), OW_DEF (output).
//   Helpers return MAXW-bit signed constants; callers cast them down to their own width.
package fir_mac_pkg;

    localparam int unsigned AW_DEF   = 18;
    localparam int unsigned BW_DEF   = 36;
    localparam int unsigned LW_DEF   = 18;
    localparam int unsigned HW_DEF   = BW_DEF - LW_DEF;
    localparam int unsigned ACCW_DEF = 68;
    localparam int unsigned OW_DEF   = 68;

    // Width of the helper return values; must exceed any ACCW in use.
    localparam int unsigned MAXW = 128;

    // Largest value representable in a w-bit two's complement number.
    function automatic logic signed [MAXW-1:0] sat_max(input int unsigned w);
        sat_max = (MAXW'(1) <<< (w - 1)) - MAXW'(1);
    endfunction

    // Smallest value representable in a w-bit two's complement number.
    function automatic logic signed [MAXW-1:0] sat_min(input int unsigned w);
        sat_min = ~sat_max(w);
    endfunction

    // Half an LSB of the shifted result; zero when no shift is applied.
    function automatic logic signed [MAXW-1:0] round_const(input int unsigned shift);
        round_const = (shift == 0) ? MAXW'(0) : (MAXW'(1) <<< (shift - 1));
    endfunction

endpackage

// File: rtl/fir_mac_round_sat.sv
// Round-half-up, arithmetic right shift and saturate a wide sum to a narrower output.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   in_valid     : sum is a result to be emitted this cycle
//   sum          : signed ACCW-bit sum
//   out_valid    : one-cycle pulse, registered
//   out_data     : rounded/saturated result, held between pulses
//   out_sat      : out_data was clipped, held between pulses
module fir_mac_round_sat
    import fir_mac_pkg::*;
#(
    parameter int unsigned ACCW  = ACCW_DEF,
    parameter int unsigned OW    = OW_DEF,
    parameter int unsigned SHIFT = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic signed [ACCW-1:0] sum,
    output logic                   out_valid,
    output logic signed [OW-1:0]   out_data,
    output logic                   out_sat
);

    // One guard bit so adding the rounding constant cannot lose the carry.
    localparam int unsigned RW = ACCW + 1;
    localparam logic signed [RW-1:0] RND  = RW'(round_const(SHIFT));
    localparam logic signed [RW-1:0] MAXV = RW'(sat_max(OW));
    localparam logic signed [RW-1:0] MINV = RW'(sat_min(OW));

    logic signed [RW-1:0] sum_x;
    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] r;

    assign sum_x   = RW'(sum);
    assign rnd_sum = sum_x + RND;
    assign r       = rnd_sum >>> SHIFT;

    // Output register: pulse on valid, otherwise hold the last result.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                if (r > MAXV) begin
                    out_data <= MAXV[OW-1:0];
                    out_sat  <= 1'b1;
                end else if (r < MINV) begin
                    out_data <= MINV[OW-1:0];
                    out_sat  <= 1'b1;
                end else begin
                    out_data <= r[OW-1:0];
                    out_sat  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fir_mac_split_acc.sv
// Pipelined signed MAC for FIR tap chains with the coefficient split into an unsigned
// low slice and a signed high slice, accumulated separately and recombined at the end.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   in_valid/in_last : tap strobe and end-of-sequence marker (last qualified by valid)
//   a, b             : signed sample and signed coefficient
//   out_valid        : one-cycle pulse per completed sequence, 4 edges after the last tap
//   out_data/out_sat : rounded/saturated sequence sum and clip flag
module fir_mac_split_acc
    import fir_mac_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned LW    = LW_DEF,
    parameter int unsigned ACCW  = ACCW_DEF,
    parameter int unsigned OW    = OW_DEF,
    parameter int unsigned SHIFT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat
);

    localparam int unsigned HW  = BW - LW;
    localparam int unsigned PLW = AW + LW + 1;
    localparam int unsigned PHW = AW + HW;
    localparam int unsigned HAW = ACCW - LW;

    // Stage 1: input register.
    logic                 s1_valid, s1_last;
    logic signed [AW-1:0] s1_a;
    logic signed [BW-1:0] s1_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_last  <= in_valid & in_last;
            s1_a     <= a;
            s1_b     <= b;
        end
    end

    // Stage 2: partial products; the low slice gets a zero sign bit so it stays unsigned.
    logic signed [LW:0]    b_lo;
    logic signed [HW-1:0]  b_hi;
    logic signed [PLW-1:0] p_lo_c;
    logic signed [PHW-1:0] p_hi_c;

    assign b_lo   = $signed({1'b0, s1_b[LW-1:0]});
    assign b_hi   = s1_b[BW-1:LW];
    assign p_lo_c = PLW'(s1_a) * PLW'(b_lo);
    assign p_hi_c = PHW'(s1_a) * PHW'(b_hi);

    logic                  s2_valid, s2_last;
    logic signed [PLW-1:0] s2_plo;
    logic signed [PHW-1:0] s2_phi;

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_plo   <= '0;
            s2_phi   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_plo   <= p_lo_c;
            s2_phi   <= p_hi_c;
        end
    end

    // Stage 3: split accumulators; the first tap of a sequence overwrites instead of adding.
    logic                   first;
    logic                   s3_valid, s3_last;
    logic signed [ACCW-1:0] acc_lo;
    logic signed [HAW-1:0]  acc_hi;

    always_ff @(posedge clock) begin
        if (reset) begin
            first    <= 1'b1;
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            acc_lo   <= '0;
            acc_hi   <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_last  <= s2_valid & s2_last;
            if (s2_valid) begin
                first <= s2_last;
                if (first) begin
                    acc_lo <= ACCW'(s2_plo);
                    acc_hi <= HAW'(s2_phi);
                end else begin
                    acc_lo <= acc_lo + ACCW'(s2_plo);
                    acc_hi <= acc_hi + HAW'(s2_phi);
                end
            end
        end
    end

    // Recombine: high slice weighs 2^LW relative to the low slice.
    logic signed [ACCW-1:0] sum_c;

    assign sum_c = (ACCW'(acc_hi) <<< LW) + acc_lo;

    // Stage 4: round, shift and saturate.
    fir_mac_round_sat #(
        .ACCW  (ACCW),
        .OW    (OW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s3_valid & s3_last),
        .sum       (sum_c),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

endmodule

// File: tb/tb_fir_mac_split_acc.sv
// Scoreboard bench for fir_mac_split_acc: three instances (defaults; OW=16; OW=16 SHIFT=4)
// fed directed taps; expected results are queued at issue time and popped by a monitor.
module tb_fir_mac_split_acc;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    logic              iv [3];
    logic              il [3];
    logic signed [17:0] ia [3];
    logic signed [35:0] ib [3];

    logic               ov0, ov1, ov2;
    logic               os0, os1, os2;
    logic signed [67:0] od0;
    logic signed [15:0] od1, od2;

    fir_mac_split_acc u0 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_last(il[0]),
        .a(ia[0]), .b(ib[0]), .out_valid(ov0), .out_data(od0), .out_sat(os0)
    );

    fir_mac_split_acc #(.OW(16), .SHIFT(0)) u1 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_last(il[1]),
        .a(ia[1]), .b(ib[1]), .out_valid(ov1), .out_data(od1), .out_sat(os1)
    );

    fir_mac_split_acc #(.OW(16), .SHIFT(4)) u2 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_last(il[2]),
        .a(ia[2]), .b(ib[2]), .out_valid(ov2), .out_data(od2), .out_sat(os2)
    );

    typedef struct {
        logic signed [67:0] data;
        logic               sat;
        int                 cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int cyc     = 0;
    int n_total = 0;
    int n_pass  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int k,
                       input logic signed [67:0] got, input logic signed [67:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s u%0d: got %0d, expected %0d", name, k, got, want);
    endtask

    task automatic score(input int k, input logic signed [67:0] d, input logic s);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_total++;
            $display("FAIL unexpected_pulse u%0d: got pulse with data %0d, expected no pulse", k, d);
        end else begin
            chk("data", k, d, e.data);
            chk("sat", k, 68'(s), 68'(e.sat));
            chk("latency", k, 68'(cyc), 68'(e.cyc));
        end
    endtask

    // Monitor: compare every output pulse against the head of its queue.
    always @(negedge clock) begin
        if (ov0) score(0, od0, os0);
        if (ov1) score(1, 68'(od1), os1);
        if (ov2) score(2, 68'(od2), os2);
    end

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            il[i] = 1'b0;
            ia[i] = '0;
            ib[i] = '0;
        end
    endtask

    // One tap on instance k; on the last tap queue the expected result 4 edges ahead.
    task automatic tap(input int k, input int a, input longint b, input bit last,
                       input longint ed = 0, input bit es = 1'b0);
        exp_t e;
        @(negedge clock);
        clear_inputs();
        iv[k] = 1'b1;
        il[k] = last;
        ia[k] = 18'(a);
        ib[k] = 36'(b);
        if (last) begin
            e.data = 68'(ed);
            e.sat  = es;
            e.cyc  = cyc + 4;
            case (k)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            clear_inputs();
        end
    endtask

    // in_last without in_valid must be ignored.
    task automatic bubble_last(input int k);
        @(negedge clock);
        clear_inputs();
        il[k] = 1'b1;
        ia[k] = 18'(77);
        ib[k] = 36'(77);
    endtask

    initial begin
        int budget;
        clear_inputs();
        repeat (3) @(negedge clock);
        chk("reset_valid", 0, 68'(ov0), 68'(0));
        chk("reset_data", 0, od0, 68'(0));
        chk("reset_sat", 0, 68'(os0), 68'(0));
        chk("reset_valid", 1, 68'(ov1), 68'(0));
        chk("reset_data", 1, 68'(od1), 68'(0));
        chk("reset_valid", 2, 68'(ov2), 68'(0));
        chk("reset_data", 2, 68'(od2), 68'(0));
        reset = 1'b0;

        // Default widths: basic product, unsigned low slice, bubbles, back-to-back.
        tap(0, 3, 5, 1'b1, 15);
        idle(2);
        tap(0, -1, 64'h3FFFF, 1'b1, -262143);
        tap(0, 1, -64'sd34359738368, 1'b0);
        tap(0, 2, 1, 1'b0);
        idle(1);
        bubble_last(0);
        tap(0, 3, 262144, 1'b0);
        tap(0, 4, -1, 1'b1, -64'sd34358951938);
        tap(0, 2, 7, 1'b1, 14);
        tap(0, -5, 3, 1'b0);
        tap(0, 1, 1, 1'b1, -14);
        idle(7);
        chk("hold_data", 0, od0, -68'sd14);
        chk("hold_valid", 0, 68'(ov0), 68'(0));

        // OW=16, no shift: saturation and exact-limit boundaries.
        tap(1, 131071, 131072, 1'b1, 32767, 1'b1);
        tap(1, -131072, 131072, 1'b1, -32768, 1'b1);
        tap(1, 32767, 1, 1'b1, 32767, 1'b0);
        tap(1, -32768, 1, 1'b1, -32768, 1'b0);
        tap(1, 16384, 2, 1'b1, 32767, 1'b1);
        tap(1, -16385, 2, 1'b1, -32768, 1'b1);
        tap(1, 100, -300, 1'b0);
        tap(1, 10, 300, 1'b1, -27000, 1'b0);

        // OW=16, SHIFT=4: round-half-up and saturation after rounding.
        tap(2, 24, 1, 1'b1, 2);
        tap(2, -24, 1, 1'b1, -1);
        tap(2, 8, 1, 1'b1, 1);
        tap(2, 7, 1, 1'b1, 0);
        tap(2, -8, 1, 1'b1, 0);
        tap(2, -9, 1, 1'b1, -1);
        tap(2, 131071, 4, 1'b0);
        tap(2, -5, 1, 1'b1, 32767, 1'b0);
        tap(2, 65535, 8, 1'b1, 32767, 1'b1);
        tap(2, 131071, 131072, 1'b1, 32767, 1'b1);
        idle(8);

        // Reset mid-sequence: the partial sum is dropped and never reported.
        tap(0, 1, 1, 1'b0);
        tap(0, 1, 1, 1'b0);
        tap(0, 1, 1, 1'b0);
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tap(0, 1, 1, 1'b1, 1);

        budget = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && budget < 50) begin
            idle(1);
            budget++;
        end
        idle(4);
        chk("drained", 0, 68'(q0.size()), 68'(0));
        chk("drained", 1, 68'(q1.size()), 68'(0));
        chk("drained", 2, 68'(q2.size()), 68'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
